zero_scan_unit: RTL and testbench
=================================

ZERO_SCAN_UNIT -- requirements
Module: zero_scan_unit

Interface
REQ-001 Parameter WIDTH, default 64, operand width; power of two, >= 8.
REQ-002 Parameter CHUNK, default 8, bits examined per scan cycle; power of two, divides WIDTH, CHUNK <= WIDTH.
REQ-003 Localparam CW = $clog2(WIDTH)+1, count width; NCHUNK = WIDTH/CHUNK.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start  input  1  request; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of an in-progress scan.
REQ-008 mode  input  2  00 leading zeros, 01 trailing zeros, 10 leading ones, 11 trailing ones; sampled with start.
REQ-009 data_in  input  WIDTH  operand; sampled with start.
REQ-010 count  output  CW  result run length, registered.
REQ-011 full_run  output  1  high when count == WIDTH (entire word is the scanned value).
REQ-012 busy  output  1  high while in SCAN.
REQ-013 done  output  1  one-cycle completion pulse.

Function
REQ-014 FSM states IDLE, SCAN, DONE; reset state IDLE.
REQ-015 IDLE: start=1 and abort=0 at an edge -> capture normalised operand, clear scan accumulator and chunk index, go SCAN; otherwise stay.
REQ-016 Normalisation: trailing modes bit-reverse data_in; ones modes invert data_in; scan then always counts leading zeros from MSB.
REQ-017 SCAN, each edge: examine top CHUNK bits of working register.
REQ-018 Chunk all zero and not last chunk -> accumulator += CHUNK, shift working register left by CHUNK, index += 1, stay SCAN.
REQ-019 Chunk all zero and last chunk -> count = WIDTH, full_run = 1, go DONE.
REQ-020 Chunk non-zero -> count = accumulator + leading-zero count within chunk, full_run = 0, go DONE.
REQ-021 Latency: start sampled at edge E0; result written at edge Ek, k = index of first chunk holding a non-scanned bit + 1 (k = NCHUNK if none); done high in the cycle after Ek; IDLE after Ek+1.
REQ-022 Minimum latency 1 scan cycle; maximum NCHUNK scan cycles.
REQ-023 count and full_run change only on SCAN->DONE; held stable until next completed scan.
REQ-024 done = 1 only in DONE, exactly one cycle per completed scan; busy = 1 only in SCAN.
REQ-025 start in SCAN or DONE ignored; no queuing.
REQ-026 abort = 1 in SCAN -> go IDLE at that edge, no done, count/full_run unchanged.
REQ-027 abort in IDLE or DONE has no effect except that in IDLE it suppresses a simultaneous start.
REQ-028 data_in and mode changes after capture do not affect the running scan.

Reset
REQ-029 rst_n low -> immediately state IDLE, count 0, full_run 0, busy 0, done 0, working register and accumulator 0.
REQ-030 Reset mid-scan discards the operation; no done produced.
REQ-031 First start accepted at first rising edge after rst_n deasserts.

Structure
REQ-032 Shared package holds mode encodings (MODE_LZ, MODE_TZ, MODE_LO, MODE_TO) and the FSM state type.
REQ-033 One combinational sub-module chunk_lzc (parameter CHUNK) returns the leading-zero count and all-zero flag of one chunk; instantiated once.

Verification
REQ-034 Defaults, mode 00, data_in=0x0000_0000_0000_0001 -> 8 scan cycles, count=63, full_run=0, single done pulse.
REQ-035 Mode 00, data_in=0 -> 8 scan cycles, count=64, full_run=1; mode 10, data_in=all ones -> count=64, full_run=1.
REQ-036 Mode 00, data_in=0x8000_0000_0000_0000 -> 1 scan cycle, count=0; mode 01, data_in=0x0000_0000_0001_0000 -> 3 scan cycles, count=16.
REQ-037 Mode 11, data_in=0x0000_0000_0000_00FF -> count=8, 2 scan cycles; start pulsed during SCAN -> ignored, exactly one done.
REQ-038 Abort asserted 3rd cycle of mode 00 scan of data_in=1 -> IDLE, no done, count retains prior value; rst_n pulsed mid-scan -> all outputs 0.
REQ-039 WIDTH=32, CHUNK=4 build, 1000 random operands all modes -> count matches reference model, latency per REQ-021.

Source files
------------

// File: rtl/zero_scan_unit_pkg.sv
// Shared definitions for the zero/one run-length scanner: mode encodings and FSM state type.
package zero_scan_unit_pkg;

  localparam logic [1:0] MODE_LZ = 2'b00;
  localparam logic [1:0] MODE_TZ = 2'b01;
  localparam logic [1:0] MODE_LO = 2'b10;
  localparam logic [1:0] MODE_TO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/zero_scan_unit_chunk_lzc.sv
// Combinational leading-zero count and all-zero flag for one CHUNK-bit slice.
module chunk_lzc #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0]       chunk,
  output logic [$clog2(CHUNK):0] lzc_c,
  output logic                   all_zero_c
);

  localparam int unsigned LW = $clog2(CHUNK) + 1;

  // Walk LSB to MSB so the highest set bit has the final say.
  always_comb begin
    lzc_c = LW'(CHUNK);
    for (int unsigned i = 0; i < CHUNK; i++) begin
      if (chunk[i]) lzc_c = LW'(CHUNK - 1 - i);
    end
  end

  assign all_zero_c = ~|chunk;

endmodule

// File: rtl/zero_scan_unit.sv
// Multi-cycle leading/trailing zero/one counter; scans CHUNK bits per cycle from the MSB
// of a normalised copy of the operand.
module zero_scan_unit
  import zero_scan_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [1:0]             mode,
  input  logic [WIDTH-1:0]       data_in,
  output logic [$clog2(WIDTH):0] count,
  output logic                   full_run,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned CW     = $clog2(WIDTH) + 1;
  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned LW     = $clog2(CHUNK) + 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CW-1:0]    acc_q, acc_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [CW-1:0]    count_d;
  logic             full_run_d;
  logic             busy_d;
  logic             done_d;

  logic [LW-1:0]    chunk_lzc_c;
  logic             chunk_zero_c;

  // Map every mode onto "count leading zeros": reverse for trailing, invert for ones.
  function automatic logic [WIDTH-1:0] normalise(input logic [1:0] m, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = d;
    if (m == MODE_TZ || m == MODE_TO) begin
      for (int unsigned i = 0; i < WIDTH; i++) r[i] = d[WIDTH-1-i];
    end
    if (m == MODE_LO || m == MODE_TO) r = ~r;
    return r;
  endfunction

  chunk_lzc #(
    .CHUNK (CHUNK)
  ) u_chunk_lzc (
    .chunk      (work_q[WIDTH-1 -: CHUNK]),
    .lzc_c      (chunk_lzc_c),
    .all_zero_c (chunk_zero_c)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    work_d     = work_q;
    acc_d      = acc_q;
    idx_d      = idx_q;
    count_d    = count;
    full_run_d = full_run;

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          work_d  = normalise(mode, data_in);
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!chunk_zero_c) begin
          count_d    = acc_q + CW'(chunk_lzc_c);
          full_run_d = 1'b0;
          state_d    = ST_DONE;
        end else if (idx_q == IDXW'(NCHUNK - 1)) begin
          count_d    = CW'(WIDTH);
          full_run_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          acc_d   = acc_q + CW'(CHUNK);
          work_d  = work_q << CHUNK;
          idx_d   = idx_q + IDXW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      work_q   <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      count    <= '0;
      full_run <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      count    <= count_d;
      full_run <= full_run_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: tb/tb_zero_scan_unit.sv
// Directed and random checks of zero_scan_unit at 64/8 and 32/4 with a result scoreboard.
module tb_zero_scan_unit;

  logic        clk;
  logic        rst_n;
  logic        abort;

  logic        start64;
  logic [1:0]  mode64;
  logic [63:0] data64;
  logic [6:0]  count64;
  logic        full64, busy64, done64;

  logic        start32;
  logic [1:0]  mode32;
  logic [31:0] data32;
  logic [5:0]  count32;
  logic        full32, busy32, done32;

  typedef struct {
    int cnt;
    bit full;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   checks;
  int   failures;

  zero_scan_unit #(.WIDTH(64), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start64), .abort(abort), .mode(mode64),
    .data_in(data64), .count(count64), .full_run(full64), .busy(busy64), .done(done64)
  );

  zero_scan_unit #(.WIDTH(32), .CHUNK(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .abort(1'b0), .mode(mode32),
    .data_in(data32), .count(count32), .full_run(full32), .busy(busy32), .done(done32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk bits from the scanned end while they equal the counted value.
  function automatic int model_count(input int w, input logic [1:0] m, input logic [63:0] d);
    int   c;
    logic tgt;
    bit   run;
    c   = 0;
    run = 1'b1;
    tgt = m[1];
    for (int i = 0; i < w; i++) begin
      int b;
      b = m[0] ? i : (w - 1 - i);
      if (run && d[b] === tgt) c++;
      else run = 1'b0;
    end
    return c;
  endfunction

  // Drive start for one edge, record expectation, then scramble the inputs.
  task automatic drive_start(input bit sel32, input logic [1:0] m, input logic [63:0] d, input bit push);
    exp_t e;
    int   w, ch;
    w  = sel32 ? 32 : 64;
    ch = sel32 ? 4 : 8;
    @(negedge clk);
    if (sel32) begin start32 = 1'b1; mode32 = m; data32 = d[31:0]; end
    else begin start64 = 1'b1; mode64 = m; data64 = d; end
    if (push) begin
      e.cnt  = model_count(w, m, d);
      e.full = (e.cnt == w);
      e.lat  = e.full ? (w / ch) : (e.cnt / ch + 1);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start32 = 1'b0;
    start64 = 1'b0;
    mode32  = ~mode32;  data32 = ~data32;
    mode64  = ~mode64;  data64 = ~data64;
  endtask

  task automatic wait_done(input bit sel32, input bit pulse);
    int   n;
    bit   got;
    exp_t e;
    int   extra;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (pulse && n == 1) start64 = 1'b1;
      if (pulse && n == 2) start64 = 1'b0;
      if (sel32 ? done32 : done64) got = 1'b1;
      else if (n == 1) check("busy_in_scan", 64'(sel32 ? busy32 : busy64), 64'd1);
    end
    start64 = 1'b0;
    check("done_seen", 64'(got), 64'd1);
    if (got) begin
      check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("count", sel32 ? 64'(count32) : 64'(count64), 64'(e.cnt));
        check("full_run", 64'(sel32 ? full32 : full64), 64'(e.full));
        check("latency", 64'(n), 64'(e.lat));
      end
      @(posedge clk); #1;
      check("done_single", 64'(sel32 ? done32 : done64), 64'd0);
      check("busy_after", 64'(sel32 ? busy32 : busy64), 64'd0);
      if (pulse) begin
        extra = 0;
        repeat (6) begin
          @(posedge clk); #1;
          if (done64) extra++;
        end
        check("no_extra_done", 64'(extra), 64'd0);
      end
    end
  endtask

  task automatic watch_no_done(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (done64) seen++;
    end
    check(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    logic [31:0] r;
    logic [1:0]  m;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    abort    = 1'b0;
    start64  = 1'b0; mode64 = 2'b00; data64 = '0;
    start32  = 1'b0; mode32 = 2'b00; data32 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 64'(count64), 64'd0);
    check("rst_full", 64'(full64), 64'd0);
    check("rst_busy", 64'(busy64), 64'd0);
    check("rst_done", 64'(done64), 64'd0);

    // Release at a falling edge; the first scan starts on the very next rising edge.
    @(negedge clk);
    rst_n = 1'b1;
    start64 = 1'b1; mode64 = 2'b00; data64 = 64'h0000_0000_0000_0001;
    sb.push_back('{cnt: 63, full: 1'b0, lat: 8});
    @(posedge clk); #1;
    start64 = 1'b0; data64 = '1; mode64 = 2'b11;
    wait_done(1'b0, 1'b0);

    drive_start(1'b0, 2'b00, 64'h0, 1'b1);
    wait_done(1'b0, 1'b0);
    drive_start(1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    wait_done(1'b0, 1'b0);
    drive_start(1'b0, 2'b00, 64'h8000_0000_0000_0000, 1'b1);
    wait_done(1'b0, 1'b0);
    drive_start(1'b0, 2'b01, 64'h0000_0000_0001_0000, 1'b1);
    wait_done(1'b0, 1'b0);
    drive_start(1'b0, 2'b11, 64'h0000_0000_0000_00FF, 1'b1);
    wait_done(1'b0, 1'b1);
    drive_start(1'b0, 2'b01, 64'h0000_0000_0000_0000, 1'b1);
    wait_done(1'b0, 1'b0);
    drive_start(1'b0, 2'b11, 64'h0000_0000_0000_00FF, 1'b1);
    wait_done(1'b0, 1'b0);

    // Abort on the third scan edge: prior count of 8 must survive.
    drive_start(1'b0, 2'b00, 64'h1, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", 64'(busy64), 64'd0);
    check("abort_done", 64'(done64), 64'd0);
    check("abort_count", 64'(count64), 64'd8);
    check("abort_full", 64'(full64), 64'd0);
    watch_no_done("abort_no_done", 10);

    // Abort in IDLE suppresses a simultaneous start.
    @(negedge clk);
    abort = 1'b1; start64 = 1'b1; mode64 = 2'b00; data64 = 64'h1;
    @(posedge clk); #1;
    abort = 1'b0; start64 = 1'b0;
    check("idle_abort_busy", 64'(busy64), 64'd0);
    watch_no_done("idle_abort_no_done", 10);

    // Asynchronous reset mid-scan.
    drive_start(1'b0, 2'b00, 64'h1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_count", 64'(count64), 64'd0);
    check("midrst_full", 64'(full64), 64'd0);
    check("midrst_busy", 64'(busy64), 64'd0);
    check("midrst_done", 64'(done64), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_no_done("midrst_no_done", 10);
    drive_start(1'b0, 2'b00, 64'h00F0_0000_0000_0000, 1'b1);
    wait_done(1'b0, 1'b0);

    // Narrow build, random operands in every mode.
    for (int k = 0; k < 1000; k++) begin
      r = $urandom;
      m = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        1: r = r >> $urandom_range(0, 32);
        2: r = r << $urandom_range(0, 32);
        3: r = ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFF : 32'h0;
        default: ;
      endcase
      drive_start(1'b1, m, {32'h0, r}, 1'b1);
      wait_done(1'b1, 1'b0);
    end

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
